// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle datapath: fetch/decode/execute/memory/writeback
// sequencing with a memory-ready handshake. Optional retired-instruction counter under CTRL_FSM_PERF_CNT_EN.
module multicycle_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             MemReady,
    output logic             IRWrite,
    output logic             NextPC,
    output logic             AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             ALUOp,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_e;

    state_e state_q, state_d;

    // NOTE: state registers use non-blocking assignments; combinational blocks use blocking ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        IllegalOp = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                NextPC    = MemReady;
                if (MemReady) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: begin
                        state_d   = FETCH;
                        IllegalOp = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                state_d   = FETCH;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
                if (MemReady) state_d = FETCH;
            end
            EXECR: begin
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegW    = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // Strobes must be quiet while reset is held; the state is already FETCH, so muxes need no override.
        if (reset) begin
            IRWrite   = 1'b0;
            NextPC    = 1'b0;
            RegW      = 1'b0;
            MemW      = 1'b0;
            Branch    = 1'b0;
            IllegalOp = 1'b0;
        end
    end

`ifdef CTRL_FSM_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    assign retire = (state_q == ALUWB) || (state_q == MEMWB) || (state_q == BRANCH) ||
                    ((state_q == MEMWR) && MemReady);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       cnt_q <= '0;
        else if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign InstrCount = cnt_q;
`else
    assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm: expected strobes per cycle are queued
// when stimulus is driven and compared at the following falling edge.
module tb_multicycle_ctrl_fsm;

    localparam int CNT_W = 4;
    localparam int X     = -1;

    typedef enum {T_RST, T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
                  T_EXECR, T_EXECI, T_ALUWB, T_BRANCH} st_e;

    typedef struct packed {
        logic       irw;
        logic       npc;
        logic       adr;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic       aluop;
        logic       regw;
        logic       memw;
        logic       br;
        logic       ill;
    } out_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       Op;
    logic [5:0]       Funct;
    logic             MemReady;
    logic             IRWrite, NextPC, AdrSrc, ALUOp, RegW, MemW, Branch, IllegalOp;
    logic [1:0]       ALUSrcA, ALUSrcB, ResultSrc;
    logic [CNT_W-1:0] InstrCount;

    int          checks   = 0;
    int          failures = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    out_t        sb_q[$];
    st_e         tag_q[$];
    out_t        got;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .IllegalOp(IllegalOp), .InstrCount(InstrCount)
    );

    assign got = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW, Branch, IllegalOp};

    // Expected control word for each state, straight from the state/output table.
    function automatic out_t exp_out(input st_e s, input logic mr, input logic [1:0] op);
        out_t e = '0;
        case (s)
            T_RST:    begin e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10; end
            T_FETCH:  begin e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10; e.irw = mr; e.npc = mr; end
            T_DECODE: begin e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10; e.ill = (op == 2'b11); end
            T_MEMADR: begin e.srcb = 2'b01; end
            T_MEMRD:  begin e.adr = 1'b1; end
            T_MEMWB:  begin e.res = 2'b01; e.regw = 1'b1; end
            T_MEMWR:  begin e.adr = 1'b1; e.memw = 1'b1; end
            T_EXECR:  begin e.aluop = 1'b1; end
            T_EXECI:  begin e.srcb = 2'b01; e.aluop = 1'b1; end
            T_ALUWB:  begin e.regw = 1'b1; end
            T_BRANCH: begin e.srcb = 2'b01; e.res = 2'b10; e.br = 1'b1; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    task automatic check_outputs();
        out_t e;
        st_e  t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (got === e) else begin
            failures++;
            $error("FAIL %s ctrl: observed=%h expected=%h", t.name(), got, e);
        end
        checks++;
        assert (InstrCount === exp_cnt) else begin
            failures++;
            $error("FAIL %s count: observed=%0d expected=%0d", t.name(), InstrCount, exp_cnt);
        end
    endtask

    task automatic push_exp(input st_e s);
        sb_q.push_back(exp_out(s, MemReady, Op));
        tag_q.push_back(s);
    endtask

    // One clock of stimulus; X leaves an input random to show it is ignored in that state.
    task automatic step(input st_e s, input int op, input int fn, input int mr, input bit retire);
        Op       = (op < 0) ? 2'($urandom_range(3, 0))  : 2'(op);
        Funct    = (fn < 0) ? 6'($urandom_range(63, 0)) : 6'(fn);
        MemReady = (mr < 0) ? 1'($urandom_range(1, 0))  : 1'(mr);
        push_exp(s);
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
`ifdef CTRL_FSM_PERF_CNT_EN
        if (retire) exp_cnt = exp_cnt + CNT_W'(1);
`else
        if (retire) exp_cnt = '0;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; Op = '0; Funct = '0; MemReady = 1'b1;
        #1;
        // Reset: strobes forced low even with MemReady high
        step(T_RST, X, X, 1, 0);
        step(T_RST, X, X, 1, 0);
        reset = 1'b0;

        // DP register op, with one FETCH wait first
        step(T_FETCH,  X, X, 0, 0);
        step(T_FETCH,  X, X, 1, 0);
        step(T_DECODE, 0, 0, X, 0);
        step(T_EXECR,  X, X, X, 0);
        step(T_ALUWB,  X, X, X, 1);

        // Load with two MemReady wait cycles in MEMRD: 7 cycles
        step(T_FETCH,  X, X, 1, 0);
        step(T_DECODE, 1, 1, X, 0);
        step(T_MEMADR, X, 1, X, 0);
        step(T_MEMRD,  X, X, 0, 0);
        step(T_MEMRD,  X, X, 0, 0);
        step(T_MEMRD,  X, X, 1, 0);
        step(T_MEMWB,  X, X, X, 1);

        // Store with three wait cycles: MemW held 4 cycles
        step(T_FETCH,  X, X, 1, 0);
        step(T_DECODE, 1, 0, X, 0);
        step(T_MEMADR, X, 0, X, 0);
        step(T_MEMWR,  X, X, 0, 0);
        step(T_MEMWR,  X, X, 0, 0);
        step(T_MEMWR,  X, X, 0, 0);
        step(T_MEMWR,  X, X, 1, 1);

        // Branch, then illegal op (count unchanged)
        step(T_FETCH,  X, X, 1, 0);
        step(T_DECODE, 2, X, X, 0);
        step(T_BRANCH, X, X, X, 1);
        step(T_FETCH,  X, X, 1, 0);
        step(T_DECODE, 3, X, X, 0);
        step(T_FETCH,  X, X, 1, 0);
        step(T_DECODE, 0, 6'h20, X, 0);
        step(T_EXECI,  X, X, X, 0);
        step(T_ALUWB,  X, X, X, 1);

        // Asynchronous reset in the middle of a store wait
        step(T_FETCH,  X, X, 1, 0);
        step(T_DECODE, 1, 0, X, 0);
        step(T_MEMADR, X, 0, X, 0);
        Op = 2'($urandom_range(3, 0)); MemReady = 1'b0;
        push_exp(T_MEMWR);
        @(negedge clk);
        check_outputs();
        #2 reset = 1'b1;
        exp_cnt = '0;
        push_exp(T_RST);
        #1 check_outputs();
        @(posedge clk);
        #1;
        step(T_RST, X, X, 1, 0);
        reset = 1'b0;
        step(T_FETCH,  X, X, 1, 0);
        step(T_DECODE, 2, X, X, 0);
        step(T_BRANCH, X, X, X, 1);

        // Fresh reset, then 16 DP instructions so a 4-bit count wraps 15 -> 0
        reset = 1'b1;
        step(T_RST, X, X, 1, 0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(T_FETCH,  X, X, 1, 0);
            step(T_DECODE, 0, (i % 2) ? 6'h20 : 6'h00, X, 0);
            step((i % 2) ? T_EXECI : T_EXECR, X, X, X, 0);
            step(T_ALUWB,  X, X, X, 1);
        end
        step(T_FETCH, X, X, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
